exception_handler: RTL and testbench

Sequential exception-sequencing unit downstream of the exception detector in the processor's memory stage. It latches a detected exception and its type, captures the faulting PC and data address, flushes the pipeline for a fixed number of cycles, then redirects fetch to the matching handler vector over a valid/ready handshake. It later returns to the saved PC on `eret`, and escalates a second exception inside a handler to a permanent halt.

---
 rtl/exception_handler_pkg.sv | 24 ++
 rtl/exception_handler_if.sv | 11 +
 rtl/exception_handler_exc_flush_counter.sv | 24 ++
 rtl/exception_handler.sv | 119 +++++++++++
 tb/tb_exception_handler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exception_handler_pkg.sv
// Shared definitions for the exception sequencing unit: FSM states, cause codes
// and default handler vectors.
package exception_handler_pkg;

    typedef enum logic [2:0] {
        EXC_IDLE     = 3'd0,
        EXC_FLUSH    = 3'd1,
        EXC_REDIRECT = 3'd2,
        EXC_HANDLER  = 3'd3,
        EXC_RETURN   = 3'd4,
        EXC_HALT     = 3'd5
    } exc_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_STACK = 2'b01,
        CAUSE_MEM   = 2'b10
    } exc_cause_t;

    localparam logic [15:0] DEFAULT_STACK_VEC = 16'hFF00;
    localparam logic [15:0] DEFAULT_MEM_VEC   = 16'hFF80;
    localparam int unsigned CNT_WIDTH         = 4;

endpackage

// File: rtl/exception_handler_if.sv
// Fetch-redirect handshake between the exception handler (master) and fetch (slave).
interface exception_handler_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic                redirect_valid_o;
    logic [PC_WIDTH-1:0] redirect_pc_o;
    logic                redirect_ready_i;

    modport master (output redirect_valid_o, output redirect_pc_o, input redirect_ready_i);
    modport slave  (input redirect_valid_o, input redirect_pc_o, output redirect_ready_i);
endinterface

// File: rtl/exception_handler_exc_flush_counter.sv
// Loadable down-counter with zero flag; times the pipeline flush window.
module exc_flush_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/exception_handler.sv
// Exception sequencer: capture fault, flush, redirect to handler vector,
// return to EPC on eret, halt on a fault inside the handler.
module exception_handler
    import exception_handler_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]  STACK_VEC    = DEFAULT_STACK_VEC,
    parameter logic [PC_WIDTH-1:0]  MEM_VEC      = DEFAULT_MEM_VEC,
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exception,
    input  logic                exc_type,
    input  logic [PC_WIDTH-1:0] pc_mem,
    input  logic [15:0]         mem_address,
    input  logic                eret,
    exception_handler_if.master redir,
    output logic                flush_o,
    output logic [PC_WIDTH-1:0] epc_o,
    output logic [15:0]         badaddr_o,
    output logic [1:0]          cause_o,
    output logic                in_handler_o,
    output logic                halt_o
);
    exc_state_t          state;
    exc_cause_t          cause_q;
    logic                redirect_valid_q;
    logic [PC_WIDTH-1:0] redirect_pc_q;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

    assign cnt_load = (state == EXC_IDLE) && exception;
    assign cnt_dec  = (state == EXC_FLUSH);

    exc_flush_counter #(.WIDTH(CNT_WIDTH)) u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_WIDTH'(FLUSH_CYCLES - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Outputs are registered alongside each state transition so none depends
    // combinationally on an input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= EXC_IDLE;
            flush_o          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            in_handler_o     <= 1'b0;
            halt_o           <= 1'b0;
            epc_o            <= '0;
            badaddr_o        <= '0;
            cause_q          <= CAUSE_NONE;
        end else begin
            case (state)
                EXC_IDLE: begin
                    if (exception) begin
                        epc_o     <= pc_mem;
                        badaddr_o <= mem_address;
                        cause_q   <= exc_type ? CAUSE_STACK : CAUSE_MEM;
                        flush_o   <= 1'b1;
                        state     <= EXC_FLUSH;
                    end
                end
                EXC_FLUSH: begin
                    if (cnt_zero) begin
                        flush_o          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= (cause_q == CAUSE_STACK) ? STACK_VEC : MEM_VEC;
                        state            <= EXC_REDIRECT;
                    end
                end
                EXC_REDIRECT: begin
                    if (redir.redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                        in_handler_o     <= 1'b1;
                        state            <= EXC_HANDLER;
                    end
                end
                EXC_HANDLER: begin
                    if (exception) begin
                        in_handler_o <= 1'b0;
                        halt_o       <= 1'b1;
                        flush_o      <= 1'b1;
                        state        <= EXC_HALT;
                    end else if (eret) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= epc_o;
                        state            <= EXC_RETURN;
                    end
                end
                EXC_RETURN: begin
                    if (redir.redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                        in_handler_o     <= 1'b0;
                        state            <= EXC_IDLE;
                    end
                end
                EXC_HALT: begin
                    state <= EXC_HALT;
                end
                default: begin
                    state <= EXC_IDLE;
                end
            endcase
        end
    end

    assign redir.redirect_valid_o = redirect_valid_q;
    assign redir.redirect_pc_o    = redirect_pc_q;
    assign cause_o                = cause_q;
endmodule

// File: tb/tb_exception_handler.sv
// Self-checking bench for exception_handler: vector table of exception/return
// scenarios plus hand-written double-fault and reset corner cases.
module tb_exception_handler;
    import exception_handler_pkg::*;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic        exc_type;
    logic [15:0] pc_mem;
    logic [15:0] mem_address;
    logic        eret;
    logic        flush_o;
    logic [15:0] epc_o;
    logic [15:0] badaddr_o;
    logic [1:0]  cause_o;
    logic        in_handler_o;
    logic        halt_o;

    exception_handler_if #(.PC_WIDTH(16)) redir();

    exception_handler #(
        .PC_WIDTH     (16),
        .STACK_VEC    (16'hFF00),
        .MEM_VEC      (16'hFF80),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exception    (exception),
        .exc_type     (exc_type),
        .pc_mem       (pc_mem),
        .mem_address  (mem_address),
        .eret         (eret),
        .redir        (redir),
        .flush_o      (flush_o),
        .epc_o        (epc_o),
        .badaddr_o    (badaddr_o),
        .cause_o      (cause_o),
        .in_handler_o (in_handler_o),
        .halt_o       (halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        typ;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] vec;
        logic [1:0]  cause;
        int unsigned delay;
        bit          noise;
    } vec_t;

    vec_t        tbl[4];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed redirect transfer pops the oldest expected target.
    always @(negedge clk) begin
        if (!rst && redir.redirect_valid_o && redir.redirect_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0h expected no transfer", redir.redirect_pc_o);
            end else begin
                chk("sb_redirect_pc", {16'h0, redir.redirect_pc_o}, {16'h0, sb.pop_front()});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_valid"}, redir.redirect_valid_o, 0);
        chk({tag, "_pc"}, redir.redirect_pc_o, 0);
        chk({tag, "_epc"}, epc_o, 0);
        chk({tag, "_badaddr"}, badaddr_o, 0);
        chk({tag, "_cause"}, cause_o, 0);
        chk({tag, "_in_handler"}, in_handler_o, 0);
        chk({tag, "_halt"}, halt_o, 0);
    endtask

    task automatic handshake(input string tag, input logic [15:0] exp_pc,
                             input int unsigned delay, input bit noise);
        redir.redirect_ready_i = 1'b0;
        for (int unsigned k = 0; k <= delay; k++) begin
            chk({tag, "_valid"}, redir.redirect_valid_o, 1);
            chk({tag, "_pc"}, redir.redirect_pc_o, exp_pc);
            if (noise) begin
                exception = 1'b1;
                pc_mem    = 16'hDEAD;
                exc_type  = ~exc_type;
            end
            if (k == delay) redir.redirect_ready_i = 1'b1;
            step();
        end
        redir.redirect_ready_i = 1'b0;
        exception              = 1'b0;
        chk({tag, "_valid_drop"}, redir.redirect_valid_o, 0);
    endtask

    task automatic run_exc(input vec_t v);
        int unsigned nflush;
        exception   = 1'b1;
        exc_type    = v.typ;
        pc_mem      = v.pc;
        mem_address = v.addr;
        sb.push_back(v.vec);
        step();
        exception = 1'b0;
        nflush    = 0;
        while (flush_o && nflush < 20) begin
            nflush++;
            if (v.noise) begin
                exception = 1'b1;
                pc_mem    = 16'hBEEF;
                exc_type  = ~v.typ;
            end
            step();
        end
        exception = 1'b0;
        chk("flush_len", nflush, FC);
        handshake("entry", v.vec, v.delay, v.noise);
        chk("entry_in_handler", in_handler_o, 1);
        chk("entry_epc", epc_o, v.pc);
        chk("entry_badaddr", badaddr_o, v.addr);
        chk("entry_cause", cause_o, v.cause);
    endtask

    task automatic run_ret(input vec_t v);
        eret = 1'b1;
        sb.push_back(v.pc);
        step();
        eret = 1'b0;
        chk("ret_in_handler", in_handler_o, 1);
        handshake("ret", v.pc, v.delay, v.noise);
        chk("ret_in_handler_fall", in_handler_o, 0);
        chk("ret_flush", flush_o, 0);
        chk("ret_cause_sticky", cause_o, v.cause);
        chk("ret_epc_sticky", epc_o, v.pc);
        chk("ret_badaddr_sticky", badaddr_o, v.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned nflush;
        tbl[0] = '{typ: 1'b1, pc: 16'h0040, addr: 16'h1234, vec: 16'hFF00, cause: 2'b01, delay: 0, noise: 1'b0};
        tbl[1] = '{typ: 1'b0, pc: 16'h0100, addr: 16'hFF10, vec: 16'hFF80, cause: 2'b10, delay: 3, noise: 1'b0};
        tbl[2] = '{typ: 1'b1, pc: 16'h0200, addr: 16'h0008, vec: 16'hFF00, cause: 2'b01, delay: 2, noise: 1'b1};
        tbl[3] = '{typ: 1'b0, pc: 16'hABCE, addr: 16'h0000, vec: 16'hFF80, cause: 2'b10, delay: 1, noise: 1'b1};

        rst                    = 1'b1;
        exception              = 1'b0;
        exc_type               = 1'b0;
        pc_mem                 = '0;
        mem_address            = '0;
        eret                   = 1'b0;
        redir.redirect_ready_i = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        // eret while idle must not redirect
        eret = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_eret_valid", redir.redirect_valid_o, 0);
            chk("idle_eret_flush", flush_o, 0);
        end
        eret = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_exc(tbl[i]);
            run_ret(tbl[i]);
        end

        // Double fault: exception and eret together inside the handler
        run_exc(tbl[0]);
        exception = 1'b1;
        eret      = 1'b1;
        pc_mem    = 16'h7777;
        step();
        exception = 1'b0;
        eret      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("halt_halt", halt_o, 1);
            chk("halt_flush", flush_o, 1);
            chk("halt_valid", redir.redirect_valid_o, 0);
            chk("halt_epc", epc_o, 16'h0040);
            chk("halt_cause", cause_o, 2'b01);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("halt_reset");

        // Reset in the middle of a stalled redirect
        exception   = 1'b1;
        exc_type    = 1'b0;
        pc_mem      = 16'h0300;
        mem_address = 16'h4444;
        sb.push_back(16'hFF80);
        step();
        exception = 1'b0;
        nflush    = 0;
        while (flush_o && nflush < 20) begin
            nflush++;
            step();
        end
        chk("midredir_valid", redir.redirect_valid_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        chk_all_zero("midredir_reset");
        run_exc(tbl[1]);
        run_ret(tbl[1]);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
